// File: rtl/nibble_serial_adder_ctrl.sv
// Purpose: WIDTH-bit add (optionally subtract) done one nibble per clock through a
//          single 4-bit slice, LSB first, with the carry registered between nibbles.
// Latency: accept on edge E0 gives out_valid high after edge E0+NIB; busy for NIB cycles.
// Backpressure: in_ready is low in RUN/DONE; the result is held in DONE until out_ready.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     operand handshake for a, b, cin (and sub when enabled)
//   out_valid/out_ready   result handshake for sum, cout
//   sum, cout             registered result; held until the next completion or a reset
//   busy                  high while nibble steps are in progress (RUN)
//
// Build option: define ADDSUB_SEL_EN to add the 'sub' input. sub=1 selects a-b
// (two's complement); cout=1 then means no borrow.
//
// WIDTH must be a multiple of 4 and at least 4.

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDSUB_SEL_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIB  = WIDTH / 4;
    // Keep the index at least one bit wide so WIDTH=4 still elaborates.
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  acc;
    logic              carry_q;
    logic [IDXW-1:0]   idx;

    logic [IDXW+1:0]   base;
    logic [3:0]        a_nib;
    logic [3:0]        b_nib;
    logic [4:0]        slice;
    logic [WIDTH-1:0]  acc_upd;

    // The shared 4-bit slice and the accumulator as it looks after this step.
    // acc_upd lets the last step write the final nibble straight into sum.
    always_comb begin
        base    = {idx, 2'b00};
        a_nib   = a_q[base +: 4];
        b_nib   = b_q[base +: 4];
        slice   = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
        acc_upd = acc;
        acc_upd[base +: 4] = slice[3:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            carry_q   <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q <= a;
`ifdef ADDSUB_SEL_EN
                        // Subtract as a + ~b + 1; cin is ignored in that mode.
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : cin;
`else
                        b_q     <= b;
                        carry_q <= cin;
`endif
                        idx      <= '0;
                        state    <= S_RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end

                S_RUN: begin
                    acc     <= acc_upd;
                    carry_q <= slice[4];
                    if (idx == LAST_IDX) begin
                        // Last step still executes; publish its result this edge.
                        sum       <= acc_upd;
                        cout      <= slice[4];
                        idx       <= '0;
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                S_DONE: begin
                    // in_ready stays low here: no accept in the same cycle as the drain.
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Purpose: directed self-checking bench for nibble_serial_adder_ctrl (WIDTH=16).
// Latency: expects out_valid exactly 4 cycles after the accepting edge.
// Backpressure: exercises held out_ready=0, back-to-back accepts and reset mid-run.

module tb_nibble_serial_adder_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
`ifdef ADDSUB_SEL_EN
    logic        sub;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        busy;

    int n_checks;
    int n_pass;

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADDSUB_SEL_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands, wait for acceptance, scramble the inputs, then wait for out_valid.
    // lat = cycles from accept edge to out_valid (-1 on timeout); bc = cycles busy was seen.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                          output int lat, output int bc);
        a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; cin = ~tc;
        lat = -1;
        bc  = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                lat = i;
                break;
            end
            if (busy) bc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, busy, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000})
            $display("FAIL reset_state: got rdy=%b vld=%b busy=%b cout=%b sum=%h, want 1 0 0 0 0000",
                     in_ready, out_valid, busy, cout, sum);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL idle_ready: got %b want 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_basic();
        int lat, bc;
        run_op(16'h1234, 16'h4321, 1'b0, lat, bc);
        n_checks++;
        if (lat !== 4) $display("FAIL basic_latency: got %0d want 4", lat);
        else n_pass++;
        n_checks++;
        if (bc !== 4) $display("FAIL basic_busy_cycles: got %0d want 4", bc);
        else n_pass++;
        n_checks++;
        if ({cout, sum} !== {1'b0, 16'h5555})
            $display("FAIL basic_sum: got cout=%b sum=%h want 0 5555", cout, sum);
        else n_pass++;
        drain();
        n_checks++;
        if ({out_valid, in_ready, sum} !== {1'b0, 1'b1, 16'h5555})
            $display("FAIL basic_drain: got vld=%b rdy=%b sum=%h want 0 1 5555", out_valid, in_ready, sum);
        else n_pass++;
    endtask

    task automatic test_carry_ripple();
        int lat, bc;
        run_op(16'hFFFF, 16'h0000, 1'b1, lat, bc);
        n_checks++;
        if (lat !== 4 || {cout, sum} !== {1'b1, 16'h0000})
            $display("FAIL carry_ripple: got lat=%0d cout=%b sum=%h want 4 1 0000", lat, cout, sum);
        else n_pass++;
        drain();
    endtask

    task automatic test_hold();
        int lat, bc;
        run_op(16'h8F0F, 16'h80F1, 1'b0, lat, bc);
        n_checks++;
        if (lat !== 4 || {cout, sum} !== {1'b1, 16'h1000})
            $display("FAIL hold_sum: got lat=%0d cout=%b sum=%h want 4 1 1000", lat, cout, sum);
        else n_pass++;
        // A new request during DONE must be ignored.
        a = 16'h1111; b = 16'h2222; cin = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, in_ready, busy, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b1, 16'h1000})
                $display("FAIL hold_cycle%0d: got vld=%b rdy=%b busy=%b cout=%b sum=%h want 1 0 0 1 1000",
                         i, out_valid, in_ready, busy, cout, sum);
            else n_pass++;
        end
        in_valid = 1'b0;
        drain();
        @(posedge clk); #1;
        n_checks++;
        if ({busy, in_ready, sum} !== {1'b0, 1'b1, 16'h1000})
            $display("FAIL hold_no_accept: got busy=%b rdy=%b sum=%h want 0 1 1000", busy, in_ready, sum);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        a = 16'h0001; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;                       // E0: first accept
        a = 16'h00FF; b = 16'h0001;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL b2b_accept1: got busy=%b want 1", busy);
        else n_pass++;
        repeat (4) @(posedge clk);                // E1..E4
        #1;
        n_checks++;
        if ({out_valid, cout, sum} !== {1'b1, 1'b0, 16'h0002})
            $display("FAIL b2b_result1: got vld=%b cout=%b sum=%h want 1 0 0002", out_valid, cout, sum);
        else n_pass++;
        @(posedge clk); #1;                       // E5: DONE exits
        n_checks++;
        if ({out_valid, in_ready, busy} !== {1'b0, 1'b1, 1'b0})
            $display("FAIL b2b_gap: got vld=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
        else n_pass++;
        @(posedge clk); #1;                       // E6: second accept
        in_valid = 1'b0;
        n_checks++;
        if ({busy, in_ready} !== {1'b1, 1'b0})
            $display("FAIL b2b_accept2: got busy=%b rdy=%b want 1 0", busy, in_ready);
        else n_pass++;
        repeat (4) @(posedge clk);                // E7..E10
        #1;
        n_checks++;
        if ({out_valid, cout, sum} !== {1'b1, 1'b0, 16'h0100})
            $display("FAIL b2b_result2: got vld=%b cout=%b sum=%h want 1 0 0100", out_valid, cout, sum);
        else n_pass++;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midrun();
        int lat, bc, seen;
        a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;                       // accept
        in_valid = 1'b0;
        @(posedge clk); #1;                       // now in 2nd RUN cycle
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, busy, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000})
            $display("FAIL midrun_reset: got rdy=%b vld=%b busy=%b cout=%b sum=%h want 1 0 0 0 0000",
                     in_ready, out_valid, busy, cout, sum);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid || busy) seen++;
        end
        n_checks++;
        if (seen !== 0) $display("FAIL midrun_no_valid: got %0d active cycles want 0", seen);
        else n_pass++;
        run_op(16'h7FFF, 16'h0001, 1'b0, lat, bc);
        n_checks++;
        if (lat !== 4 || {cout, sum} !== {1'b0, 16'h8000})
            $display("FAIL midrun_recover: got lat=%0d cout=%b sum=%h want 4 0 8000", lat, cout, sum);
        else n_pass++;
        drain();
    endtask

`ifdef ADDSUB_SEL_EN
    task automatic test_sub();
        int lat, bc;
        sub = 1'b1;
        run_op(16'h0005, 16'h0007, 1'b0, lat, bc);
        n_checks++;
        if (lat !== 4 || {cout, sum} !== {1'b0, 16'hFFFE})
            $display("FAIL sub_borrow: got lat=%0d cout=%b sum=%h want 4 0 fffe", lat, cout, sum);
        else n_pass++;
        drain();
        run_op(16'h0007, 16'h0005, 1'b0, lat, bc);
        n_checks++;
        if (lat !== 4 || {cout, sum} !== {1'b1, 16'h0002})
            $display("FAIL sub_noborrow: got lat=%0d cout=%b sum=%h want 4 1 0002", lat, cout, sum);
        else n_pass++;
        drain();
        sub = 1'b0;
    endtask
`endif

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b0;
`ifdef ADDSUB_SEL_EN
        sub       = 1'b0;
`endif
        #2;
        test_reset();
        test_basic();
        test_carry_ripple();
        test_hold();
        test_back_to_back();
        test_reset_midrun();
`ifdef ADDSUB_SEL_EN
        test_sub();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Sequencer that time-shares one 4-bit add slice, {carry,sum} = a + b + c, across the nibbles of a WIDTH-bit operand pair. It adds one nibble per clock, LSB first, with a registered carry between nibbles.
It sits between an operand producer and a result consumer. Both sides use valid/ready handshakes. It trades latency for area in place of a full-width adder.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4
NIB, WIDTH/4, localparam; number of nibble steps per operation

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a, b, cin are valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in to nibble 0
out_valid  output  1  sum/cout valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  registered result
cout  output  1  registered carry-out of the top nibble
busy  output  1  high in RUN

Behaviour:
- Clock and reset: one clock (clk); rst_n is asynchronous, active-low. Assertion immediately forces IDLE and clears every register.
- Reset values: in_ready=1, out_valid=0, busy=0, sum=0, cout=0, nibble index=0, carry register=0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture a, b into operand registers, load carry register with cin, set index=0, go to RUN.
  - RUN: busy=1, in_ready=0. Each cycle, the slice adds a[4k+3:4k], b[4k+3:4k] and the carry register, where k=index. The 4-bit result goes to nibble k of an internal accumulator; slice carry goes to the carry register; index increments.
    - When index==NIB-1, the step still executes. On that edge, copy the accumulator (including the final nibble) to sum, copy the slice carry to cout, and go to DONE.
  - DONE: out_valid=1, in_ready=0. sum/cout are held stable. On out_ready, go to IDLE with out_valid=0.
- Latency: operands accepted on edge E0; out_valid is high after edge E0+NIB (4 cycles for WIDTH=16).
- Throughput: one operation per NIB+2 cycles at most. in_ready is never asserted in DONE, so there is no same-cycle accept-and-drain.
- Input stability: changes to a, b or cin after acceptance have no effect; only captured copies are used.
- sum/cout change only on entry to DONE and otherwise hold the last result, including across IDLE. Reset clears them.
- Arithmetic: {cout,sum} equals a+b+cin modulo 2^(WIDTH+1) and is bit-identical to a full-width add. Wrap-around (e.g. all-ones + 1) gives sum=0, cout=1.
- in_valid while busy or in DONE is ignored; the producer must hold it until in_ready.
- Holding out_ready=1 continuously gives a DONE dwell of exactly one cycle.
- Reset during RUN or DONE: the operation is aborted, there is no out_valid pulse, and the next accept after release behaves normally.
- WIDTH=4: RUN lasts exactly one cycle.

Optional Feature:
- Macro ADDSUB_SEL_EN.
- When defined: adds input port sub (1 bit), captured with the operands on accept.
  - If sub=1, the B operand register loads ~b and the carry register loads 1, ignoring cin.
  - Result is a-b in two's complement; cout=1 means no borrow.
- When undefined: no sub port; add-only behaviour as above.

Test Plan:
- Reset, then a=16'h1234, b=16'h4321, cin=0 -> out_valid high exactly 4 cycles after accept; sum=16'h5555, cout=0; busy high for 4 cycles.
- a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1. This checks the carry ripple through all nibble steps.
- a=16'h8F0F, b=16'h80F1, cin=0 with out_ready held 0 for 5 cycles -> sum=16'h1000, cout=1, stable throughout. in_ready stays 0 and a new in_valid during that window is not accepted.
- Back-to-back: in_valid held high with 0x0001+0x0001 then 0x00FF+0x0001, out_ready=1 -> results 0x0002 then 0x0100. Second accept occurs one cycle after DONE exits.
- Assert rst_n low in the 2nd RUN cycle -> outputs at reset values immediately, no out_valid. After release, 16'h7FFF+16'h0001 gives sum=16'h8000, cout=0.
- With ADDSUB_SEL_EN: sub=1, a=16'h0005, b=16'h0007 -> sum=16'hFFFE, cout=0. Then a=7, b=5 -> sum=16'h0002, cout=1.
